mux_4_1_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4:1 word mux between four requesters. It grants one requester at a time, drives the mux select, and presents the selected word to a single downstream consumer over a valid/ready handshake. Each grant is a burst capped at MAX_BURST beats, which guarantees fairness. It sits between four producer channels and one shared consumer port.

---
 rtl/mux_4_1_rr_arbiter_pkg.sv | 27 ++
 rtl/mux_4_1_rr_arbiter_mux.sv | 10 +
 rtl/mux_4_1_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_mux_4_1_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_4_1_rr_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package mux_4_1_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Result of one round-robin search over the request vector.
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Ceiling log2, never less than one bit, so that a burst counter always exists.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_4_1_rr_arbiter_mux.sv
// Single-bit 4:1 multiplexer; replicated per data bit by the arbiter top.
module mux_4_1 (
  output logic       Y,
  input  logic [3:0] I,
  input  logic [1:0] S
);

  assign Y = I[S];

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 word mux between four requesters,
// with bursts capped at MAX_BURST beats and a valid/ready output port.
module mux_4_1_rr_arbiter
  import mux_4_1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] din,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic [1:0]               sel,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy
);

  localparam int CNT_W = clog2_min1(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic  beat;
  logic  rotate;
  pick_t pick;

  // Search starts just after ptr and wraps, so ptr itself is considered last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] ptr);
    pick_t p;
    logic [1:0] idx;
    p = '{found: 1'b0, idx: 2'd0};
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ptr + 2'(off);
      if (!p.found && r[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  // Handshake: a beat is a valid word taken by the consumer while busy.
  always_comb begin
    busy      = (state_q == BUSY);
    out_valid = busy & req[sel_q];
    beat      = out_valid & out_ready;
    ack       = beat ? (NUM_REQ'(1) << sel_q) : '0;
    rotate    = busy & (~req[sel_q] | (beat & (cnt_q == LAST_BEAT)));
  end

  // Next-state: grant from IDLE, or rotate in BUSY without an idle bubble.
  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pick    = '{found: 1'b0, idx: 2'd0};
    case (state_q)
      IDLE: begin
        pick = rr_pick(req, ptr_q);
        if (pick.found) begin
          state_d = BUSY;
          grant_d = NUM_REQ'(1) << pick.idx;
          sel_d   = pick.idx;
        end
      end
      BUSY: begin
        if (rotate) begin
          ptr_d = sel_q;
          cnt_d = '0;
          // A dropped req[sel] is already zero in req, so no extra masking is needed.
          pick  = rr_pick(req, sel_q);
          if (pick.found) begin
            grant_d = NUM_REQ'(1) << pick.idx;
            sel_d   = pick.idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; ptr resets to 3 so requester 0 wins the first search.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;

  // Word datapath: one bit-level 4:1 mux per data bit, all steered by sel.
  for (genvar b = 0; b < WIDTH; b++) begin : g_mux
    mux_4_1 u_mux (
      .Y (out_data[b]),
      .I ({din[3*WIDTH+b], din[2*WIDTH+b], din[WIDTH+b], din[b]}),
      .S (sel_q)
    );
  end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Self-checking bench: directed tables, hand sequences and a reference model
// feeding a scoreboard queue of expected outputs.
module tb_mux_4_1_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [3:0]         req = '0;
  logic [4*WIDTH-1:0] din = '0;
  logic               out_ready = 1'b0;
  logic [3:0]         grant;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [3:0]         ack;
  logic               busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ack;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];

  // Reference model state
  bit   m_busy;
  int   m_sel, m_ptr, m_cnt;

  mux_4_1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .out_ready(out_ready),
    .grant(grant), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s, input logic v,
                              input logic [3:0] a, input logic b);
    exp_t e;
    e.grant = g; e.sel = s; e.valid = v; e.ack = a; e.busy = b;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [3:0] r, input logic rd, input exp_t e);
    vec_t v;
    v.req = r; v.rdy = rd; v.e = e;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 3; m_cnt = 0;
  endtask

  function automatic exp_t model_out(input logic [3:0] r, input logic rd);
    exp_t e;
    e = mk(4'b0000, 2'(m_sel), 1'b0, 4'b0000, 1'b0);
    if (m_busy) begin
      e.grant = 4'(1 << m_sel);
      e.busy  = 1'b1;
      e.valid = r[m_sel];
      if (r[m_sel] && rd) e.ack = 4'(1 << m_sel);
    end
    return e;
  endfunction

  // Apply one clock edge to the model: search from ptr+1 for the next requester.
  task automatic model_step(input logic [3:0] r, input logic rd);
    bit beat, rel, found;
    int nxt;
    found = 0; nxt = 0;
    if (!m_busy) begin
      for (int k = 1; k <= 4; k++)
        if (!found && r[(m_ptr + k) % 4]) begin found = 1; nxt = (m_ptr + k) % 4; end
      if (found) begin m_busy = 1; m_sel = nxt; end
    end else begin
      beat = r[m_sel] && rd;
      rel  = !r[m_sel] || (beat && m_cnt == MAX_BURST - 1);
      if (rel) begin
        m_ptr = m_sel;
        m_cnt = 0;
        for (int k = 1; k <= 4; k++)
          if (!found && r[(m_ptr + k) % 4]) begin found = 1; nxt = (m_ptr + k) % 4; end
        if (found) m_sel = nxt; else m_busy = 0;
      end else if (beat) begin
        m_cnt++;
      end
    end
  endtask

  task automatic compare_out(input exp_t e, input string tag);
    check({tag, ".grant"}, 32'(grant), 32'(e.grant));
    check({tag, ".valid"}, 32'(out_valid), 32'(e.valid));
    check({tag, ".ack"}, 32'(ack), 32'(e.ack));
    check({tag, ".busy"}, 32'(busy), 32'(e.busy));
    if (e.busy) begin
      check({tag, ".sel"}, 32'(sel), 32'(e.sel));
      check({tag, ".data"}, 32'(out_data), 32'(din[e.sel*WIDTH +: WIDTH]));
    end
  endtask

  // One cycle: drive at the falling edge, sample 1ns later, advance the model.
  task automatic cycle(input logic [3:0] r, input logic rd, input exp_t e_tab,
                       input bit use_model, input string tag);
    exp_t e;
    @(negedge clk);
    req = r;
    out_ready = rd;
    if (use_model) begin
      din = {$urandom, $urandom} >> 32;
      din = 32'($urandom);
      sb_q.push_back(model_out(r, rd));
    end else begin
      sb_q.push_back(e_tab);
    end
    #1;
    e = sb_q.pop_front();
    compare_out(e, tag);
    model_step(r, rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vecs[21];
  exp_t idle_e;

  initial begin
    idle_e = mk(4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    din = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
    model_reset();

    // Reset held with all requesters active: everything quiet.
    rst_n = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst.grant", 32'(grant), 32'h0);
    check("rst.sel", 32'(sel), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.valid", 32'(out_valid), 32'h0);
    check("rst.ack", 32'(ack), 32'h0);
    rst_n = 1'b1;

    // Fairness: 0,1,2,3,0 with four beats each and no gap between grants.
    for (int k = 0; k < 21; k++) begin
      int g;
      g = (k / 4) % 4;
      cycle(4'b1111, 1'b1, mk(4'(1 << g), 2'(g), 1'b1, 4'(1 << g), 1'b1), 0,
            $sformatf("fair%0d", k));
    end

    // Directed table: single requester burst cap, early drop, backpressure, idle.
    vecs[0]  = mkv(4'b0100, 1, idle_e);
    for (int i = 1; i <= 5; i++)
      vecs[i] = mkv(4'b0100, 1, mk(4'b0100, 2'd2, 1, 4'b0100, 1));
    vecs[6]  = mkv(4'b0011, 1, mk(4'b0100, 2'd2, 0, 4'b0000, 1));
    vecs[7]  = mkv(4'b0011, 1, mk(4'b0001, 2'd0, 1, 4'b0001, 1));
    vecs[8]  = mkv(4'b0011, 1, mk(4'b0001, 2'd0, 1, 4'b0001, 1));
    vecs[9]  = mkv(4'b0010, 1, mk(4'b0001, 2'd0, 0, 4'b0000, 1));
    vecs[10] = mkv(4'b0010, 1, mk(4'b0010, 2'd1, 1, 4'b0010, 1));
    vecs[11] = mkv(4'b0010, 1, mk(4'b0010, 2'd1, 1, 4'b0010, 1));
    for (int i = 12; i <= 14; i++)
      vecs[i] = mkv(4'b0010, 0, mk(4'b0010, 2'd1, 1, 4'b0000, 1));
    vecs[15] = mkv(4'b1010, 1, mk(4'b0010, 2'd1, 1, 4'b0010, 1));
    vecs[16] = mkv(4'b1010, 1, mk(4'b0010, 2'd1, 1, 4'b0010, 1));
    vecs[17] = mkv(4'b1000, 1, mk(4'b1000, 2'd3, 1, 4'b1000, 1));
    vecs[18] = mkv(4'b0000, 1, mk(4'b1000, 2'd3, 0, 4'b0000, 1));
    vecs[19] = mkv(4'b0000, 1, idle_e);
    vecs[20] = mkv(4'b0000, 1, idle_e);

    do_reset();
    for (int i = 0; i < 21; i++)
      cycle(vecs[i].req, vecs[i].rdy, vecs[i].e, 0, $sformatf("vec%0d", i));

    // Asynchronous reset during beat 2 of requester 3.
    do_reset();
    cycle(4'b1000, 1, idle_e, 0, "ar.idle");
    cycle(4'b1000, 1, mk(4'b1000, 2'd3, 1, 4'b1000, 1), 0, "ar.beat1");
    cycle(4'b1000, 1, mk(4'b1000, 2'd3, 1, 4'b1000, 1), 0, "ar.beat2");
    #1;
    rst_n = 1'b0;
    #1;
    check("ar.grant", 32'(grant), 32'h0);
    check("ar.busy", 32'(busy), 32'h0);
    check("ar.valid", 32'(out_valid), 32'h0);
    check("ar.ack", 32'(ack), 32'h0);
    check("ar.sel", 32'(sel), 32'h0);
    @(negedge clk);
    req = 4'b1001;
    rst_n = 1'b1;
    model_reset();
    cycle(4'b1001, 1, mk(4'b0001, 2'd0, 1, 4'b0001, 1), 0, "ar.first");

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] r;
      logic       rd;
      r  = 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 3) != 0);
      cycle(r, rd, idle_e, 1, $sformatf("rnd%0d", i));
    end

    check("sb.empty", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
